led_bank_ctrl: RTL and testbench
================================

# led_bank_ctrl

Memory-mapped LED output controller for the board's LED bank, driven by the memory/IO decoder's chip select. It generalises the plain write-only LED latch: LED width is parametrised, it adds a per-LED blink mask with a programmable blink period and a global PWM brightness, and the CPU can read the registers back. Output is fully registered and drives the board LED pins directly.

## Interface
- LED_W, 24: number of LEDs, 17..32.
- DATA_W, 16: bus data width.
- PWM_BITS, 4: PWM resolution; duty range 0..2^PWM_BITS-1.
- led_clk  in  1  system clock.
- ledrst  in  1  reset, asynchronous, active-high; clock led_clk.
- ledcs  in  1  chip select from IO decoder.
- ledwrite  in  1  write strobe, qualified by ledcs.
- ledread  in  1  read strobe, qualified by ledcs.
- ledaddr  in  4  byte offset, halfword-aligned.
- ledwdata  in  DATA_W  write data.
- ledrdata  out  DATA_W  read data, registered.
- ledout  out  LED_W  LED drive, registered.

## Operation
- Register map (ledaddr):
  - 0x0 DATA_LO: val[15:0].
  - 0x2 DATA_HI: val[LED_W-1:16] from wdata low bits.
  - 0x4 MASK_LO / 0x6 MASK_HI: blink mask, same split as DATA.
  - 0x8 PERIOD: blink half-period in led_clk cycles, 16 bit.
  - 0xA DUTY: wdata[PWM_BITS-1:0].
  - 0xC CTRL: bit0 enable; bit1 clear, self-clearing, never stored.
- Reset values: val 0, mask 0, period 0, duty all-ones, enable 1, phase 1, counters 0, ledout 0, ledrdata 0. Enable=1 and full duty at reset mean software that only writes DATA sees plain static LEDs.
- Odd ledaddr, unmapped offsets (0xE), and ledcs low: writes ignored, reads return 0.
- CTRL write with bit1=1: val cleared to 0 on the same edge; enable takes bit0.
- Blink timer:
  - period 0: timer frozen, phase held at 1.
  - Otherwise blink_cnt increments each cycle; at blink_cnt == period-1 it returns to 0 and phase toggles.
  - A PERIOD write forces blink_cnt to 0 and phase to 1. This overrides a coincident wrap.
- PWM: pwm_cnt free-runs modulo 2^PWM_BITS. pwm_on = (duty == all-ones) | (pwm_cnt < duty). Duty 0 means always off.
- Next ledout[i] = enable & pwm_on & val[i] & (~mask[i] | phase).
- Readback: DATA_HI and MASK_HI are zero-extended; CTRL bit1 always reads 0. ledread and ledwrite together: the write applies, and the read returns the pre-write value.

## Timing
- Write at edge N: the register holds the new value after N; ledout reflects it after edge N+1. Write-to-pin latency is 1 cycle.
- Read request sampled at edge N: ledrdata valid after N and held until the next read or reset.
- Blink period with PERIOD=P: ledout toggles every P cycles for masked LEDs.
- ledrst mid-operation clears everything immediately (asynchronous). First count begins at the first edge after deassertion.

## Structure
- Package led_pkg: register offset localparams, reset constants (duty all-ones, enable 1), and CTRL bit indices.
- One sub-module, led_blink_timer: period input, load strobe, phase output.
- Everything else (register file, PWM counter, output and read muxes) lives in the top module.

## Test plan
- Reset, then write DATA_LO=0xA5A5 and DATA_HI=0x003C: ledout=0x3CA5A5 one cycle after the second write; ledrdata at 0x2 = 0x003C.
- MASK_LO=0x000F, PERIOD=4: ledout[3:0] toggle every 4 cycles, first low 4 cycles after the PERIOD write; the other bits are static.
- DUTY=4 (PWM_BITS=4): each LED is high 4 of every 16 cycles. DUTY=0 gives constant 0; DUTY=0xF gives constant val.
- CTRL=0x3: val reads 0 and ledout=0 next cycle. CTRL=0x0 with nonzero val gives ledout=0; CTRL bit1 reads back 0.
- Write to 0x1 or 0xE: no register changes; read of 0xE returns 0.
- Assert ledrst mid-blink with PWM active: ledout=0 immediately. After release, ledout stays 0 until DATA is written, then blink restarts with phase 1.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants for the LED bank controller: register offsets,
// CTRL bit positions and reset values.
package led_pkg;

    // Register offsets (byte addresses, halfword aligned)
    localparam logic [3:0] ADDR_DATA_LO = 4'h0;
    localparam logic [3:0] ADDR_DATA_HI = 4'h2;
    localparam logic [3:0] ADDR_MASK_LO = 4'h4;
    localparam logic [3:0] ADDR_MASK_HI = 4'h6;
    localparam logic [3:0] ADDR_PERIOD  = 4'h8;
    localparam logic [3:0] ADDR_DUTY    = 4'hA;
    localparam logic [3:0] ADDR_CTRL    = 4'hC;

    // CTRL register bit positions
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    // Width of the low halfword of DATA / MASK
    localparam int LO_W = 16;

    // Reset values: enabled, full brightness
    localparam logic RST_ENABLE    = 1'b1;
    localparam logic RST_DUTY_FILL = 1'b1;

endpackage

// File: rtl/led_bank_ctrl_if.sv
// CPU-side bus of the LED bank controller (chip select, strobes, data).
interface led_bank_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              ledcs;
    logic              ledwrite;
    logic              ledread;
    logic [3:0]        ledaddr;
    logic [DATA_W-1:0] ledwdata;
    logic [DATA_W-1:0] ledrdata;

    modport master (
        output ledcs, ledwrite, ledread, ledaddr, ledwdata,
        input  ledrdata
    );

    modport slave (
        input  ledcs, ledwrite, ledread, ledaddr, ledwdata,
        output ledrdata
    );
endinterface

// File: rtl/led_blink_timer.sv
// Blink half-period timer: toggles phase every 'period' cycles,
// frozen with phase high when period is zero, restarted by load.
module led_blink_timer (
    input  logic        led_clk,
    input  logic        ledrst,
    input  logic [15:0] period,
    input  logic        load,
    output logic        phase
);
    logic [15:0] cnt_r;
    logic        phase_r;

    // Counter and phase update; a load overrides a coincident wrap
    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            cnt_r   <= 16'd0;
            phase_r <= 1'b1;
        end else if (load) begin
            cnt_r   <= 16'd0;
            phase_r <= 1'b1;
        end else if (period == 16'd0) begin
            cnt_r   <= cnt_r;
            phase_r <= 1'b1;
        end else if (cnt_r == (period - 16'd1)) begin
            cnt_r   <= 16'd0;
            phase_r <= ~phase_r;
        end else begin
            cnt_r   <= cnt_r + 16'd1;
            phase_r <= phase_r;
        end
    end

    assign phase = phase_r;
endmodule

// File: rtl/led_bank_ctrl.sv
// Memory-mapped LED bank controller: static value, per-LED blink mask,
// global PWM brightness, register readback. All outputs registered.
module led_bank_ctrl
    import led_pkg::*;
#(
    parameter int LED_W    = 24,
    parameter int DATA_W   = 16,
    parameter int PWM_BITS = 4
) (
    input  logic             led_clk,
    input  logic             ledrst,
    led_bank_ctrl_if.slave   bus,
    output logic [LED_W-1:0] ledout
);
    localparam int HI_W = LED_W - LO_W;

    logic [LED_W-1:0]    val_r;
    logic [LED_W-1:0]    mask_r;
    logic [15:0]         period_r;
    logic [PWM_BITS-1:0] duty_r;
    logic                enable_r;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [LED_W-1:0]    ledout_r;
    logic [DATA_W-1:0]   rdata_r;

    logic                wr_s;
    logic                rd_s;
    logic                period_load_s;
    logic                phase_s;
    logic                pwm_on_s;
    logic [LED_W-1:0]    led_next_s;
    logic [DATA_W-1:0]   rdata_s;

    // Odd offsets never write; odd reads fall through the read mux to zero
    assign wr_s          = bus.ledcs & bus.ledwrite & ~bus.ledaddr[0];
    assign rd_s          = bus.ledcs & bus.ledread;
    assign period_load_s = wr_s & (bus.ledaddr == ADDR_PERIOD);

    led_blink_timer u_blink (
        .led_clk (led_clk),
        .ledrst  (ledrst),
        .period  (period_r),
        .load    (period_load_s),
        .phase   (phase_s)
    );

    // Register file writes; CTRL clear wipes val without being stored
    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            val_r    <= '0;
            mask_r   <= '0;
            period_r <= 16'd0;
            duty_r   <= {PWM_BITS{RST_DUTY_FILL}};
            enable_r <= RST_ENABLE;
        end else if (wr_s) begin
            case (bus.ledaddr)
                ADDR_DATA_LO: val_r[LO_W-1:0]      <= bus.ledwdata[LO_W-1:0];
                ADDR_DATA_HI: val_r[LED_W-1:LO_W]  <= bus.ledwdata[HI_W-1:0];
                ADDR_MASK_LO: mask_r[LO_W-1:0]     <= bus.ledwdata[LO_W-1:0];
                ADDR_MASK_HI: mask_r[LED_W-1:LO_W] <= bus.ledwdata[HI_W-1:0];
                ADDR_PERIOD:  period_r             <= bus.ledwdata[15:0];
                ADDR_DUTY:    duty_r               <= bus.ledwdata[PWM_BITS-1:0];
                ADDR_CTRL: begin
                    enable_r <= bus.ledwdata[CTRL_EN_BIT];
                    if (bus.ledwdata[CTRL_CLR_BIT]) begin
                        val_r <= '0;
                    end else begin
                        val_r <= val_r;
                    end
                end
                default: begin
                    val_r <= val_r;
                end
            endcase
        end else begin
            val_r <= val_r;
        end
    end

    // Free-running PWM counter, wraps modulo 2^PWM_BITS
    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            pwm_cnt_r <= '0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
        end
    end

    // Full duty is forced on so the all-ones code is truly 100 percent
    assign pwm_on_s   = (&duty_r) | (pwm_cnt_r < duty_r);
    assign led_next_s = {LED_W{enable_r & pwm_on_s}} & val_r &
                        (~mask_r | {LED_W{phase_s}});

    // Readback mux; HI halves zero-extended, CTRL clear bit reads 0
    always_comb begin
        rdata_s = '0;
        case (bus.ledaddr)
            ADDR_DATA_LO: rdata_s[LO_W-1:0]     = val_r[LO_W-1:0];
            ADDR_DATA_HI: rdata_s[HI_W-1:0]     = val_r[LED_W-1:LO_W];
            ADDR_MASK_LO: rdata_s[LO_W-1:0]     = mask_r[LO_W-1:0];
            ADDR_MASK_HI: rdata_s[HI_W-1:0]     = mask_r[LED_W-1:LO_W];
            ADDR_PERIOD:  rdata_s[15:0]         = period_r;
            ADDR_DUTY:    rdata_s[PWM_BITS-1:0] = duty_r;
            ADDR_CTRL:    rdata_s[CTRL_EN_BIT]  = enable_r;
            default:      rdata_s               = '0;
        endcase
    end

    // Output registers: LED pins every cycle, read data held between reads
    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            ledout_r <= '0;
            rdata_r  <= '0;
        end else begin
            ledout_r <= led_next_s;
            if (rd_s) begin
                rdata_r <= rdata_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign ledout       = ledout_r;
    assign bus.ledrdata = rdata_r;
endmodule

// File: tb/tb_led_bank_ctrl.sv
// Testbench for led_bank_ctrl: register table plus blink, PWM, CTRL
// and reset sequences, checked through expected-value queues.
module tb_led_bank_ctrl;
    localparam int LED_W    = 24;
    localparam int DATA_W   = 16;
    localparam int PWM_BITS = 4;

    logic             led_clk;
    logic             ledrst;
    logic [LED_W-1:0] ledout;

    led_bank_ctrl_if #(.DATA_W(DATA_W)) bus ();

    led_bank_ctrl #(.LED_W(LED_W), .DATA_W(DATA_W), .PWM_BITS(PWM_BITS)) dut (
        .led_clk (led_clk),
        .ledrst  (ledrst),
        .bus     (bus),
        .ledout  (ledout)
    );

    initial led_clk = 1'b0;
    always #5 led_clk = ~led_clk;

    typedef struct {
        logic        cs;
        logic        wr;
        logic        rd;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] rd_q[$];
    logic [31:0] led_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic cs, input logic wr, input logic rd, input logic [3:0] addr,
                           input logic [15:0] wdata, input logic [15:0] exp, input string name);
        vec_t v;
        v.cs = cs; v.wr = wr; v.rd = rd; v.addr = addr;
        v.wdata = wdata; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    // One bus cycle: drive at negedge, sample 1 ns after the posedge
    task automatic bus_op(input logic cs, input logic wr, input logic rd, input logic [3:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp, input string name);
        logic [31:0] e;
        @(negedge led_clk);
        bus.ledcs    = cs;
        bus.ledwrite = wr;
        bus.ledread  = rd;
        bus.ledaddr  = addr;
        bus.ledwdata = wdata;
        if (cs && rd) rd_q.push_back({16'h0000, exp});
        @(posedge led_clk);
        #1;
        if (cs && rd) begin
            e = rd_q.pop_front();
            check(name, {16'h0000, bus.ledrdata}, e);
        end
        bus.ledcs    = 1'b0;
        bus.ledwrite = 1'b0;
        bus.ledread  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [15:0] d);
        bus_op(1'b1, 1'b1, 1'b0, addr, d, 16'h0000, "wr");
    endtask

    task automatic rd(input logic [3:0] addr, input logic [15:0] exp, input string name);
        bus_op(1'b1, 1'b0, 1'b1, addr, 16'h0000, exp, name);
    endtask

    // Called right after a PERIOD write: phase is high for P cycles then low
    // for P, and the pins lag the phase by one cycle.
    task automatic blink_check(input int p, input logic [31:0] v, input logic [31:0] m,
                               input int ncyc, input string name);
        logic [31:0] e;
        for (int k = 1; k <= ncyc; k++) begin
            if ((((k - 1) / p) % 2) == 0) led_q.push_back(v);
            else                          led_q.push_back(v & ~m);
            @(posedge led_clk);
            #1;
            e = led_q.pop_front();
            check(name, {8'h00, ledout}, e);
        end
    endtask

    // Count cycles with ledout[0] high over one PWM period; every sample
    // must be either all-off or the full static value.
    task automatic pwm_check(input int exp_on, input logic [31:0] v, input string name);
        int on_cnt;
        int bad;
        on_cnt = 0;
        bad = 0;
        @(posedge led_clk);
        #1;
        for (int k = 0; k < 16; k++) begin
            @(posedge led_clk);
            #1;
            if (ledout[0]) on_cnt++;
            if ({8'h00, ledout} != 32'h0 && {8'h00, ledout} != v) bad++;
        end
        check({name, "_on_cycles"}, on_cnt, exp_on);
        check({name, "_shape"}, bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ledcs = 1'b0; bus.ledwrite = 1'b0; bus.ledread = 1'b0;
        bus.ledaddr = 4'h0; bus.ledwdata = 16'h0000;
        ledrst = 1'b1;

        add_vec(1'b1, 1'b0, 1'b1, 4'h0, 16'h0000, 16'hA5A5, "rd_data_lo");
        add_vec(1'b1, 1'b0, 1'b1, 4'h2, 16'h0000, 16'h003C, "rd_data_hi");
        add_vec(1'b1, 1'b0, 1'b1, 4'hA, 16'h0000, 16'h000F, "rd_duty_rst");
        add_vec(1'b1, 1'b0, 1'b1, 4'hC, 16'h0000, 16'h0001, "rd_ctrl_rst");
        add_vec(1'b1, 1'b0, 1'b1, 4'h8, 16'h0000, 16'h0000, "rd_period_rst");
        add_vec(1'b1, 1'b0, 1'b1, 4'h4, 16'h0000, 16'h0000, "rd_mask_rst");
        add_vec(1'b1, 1'b1, 1'b0, 4'h6, 16'hFFFF, 16'h0000, "wr_mask_hi");
        add_vec(1'b1, 1'b0, 1'b1, 4'h6, 16'h0000, 16'h00FF, "rd_mask_hi_zext");
        add_vec(1'b1, 1'b1, 1'b0, 4'h6, 16'h0000, 16'h0000, "wr_mask_hi_clr");
        add_vec(1'b1, 1'b1, 1'b0, 4'h1, 16'hFFFF, 16'h0000, "wr_odd");
        add_vec(1'b1, 1'b1, 1'b0, 4'hE, 16'hFFFF, 16'h0000, "wr_unmapped");
        add_vec(1'b0, 1'b1, 1'b0, 4'h0, 16'h0000, 16'h0000, "wr_cs_low");
        add_vec(1'b1, 1'b0, 1'b1, 4'h1, 16'h0000, 16'h0000, "rd_odd");
        add_vec(1'b1, 1'b0, 1'b1, 4'h0, 16'h0000, 16'hA5A5, "rd_lo_after_ignored");
        add_vec(1'b1, 1'b0, 1'b1, 4'hE, 16'h0000, 16'h0000, "rd_unmapped");
        add_vec(1'b1, 1'b0, 1'b1, 4'h2, 16'h0000, 16'h003C, "rd_hi_after_ignored");
        add_vec(1'b1, 1'b1, 1'b1, 4'h0, 16'h1234, 16'hA5A5, "rd_wr_same_cycle");
        add_vec(1'b1, 1'b0, 1'b1, 4'h0, 16'h0000, 16'h1234, "rd_after_rw");
        add_vec(1'b1, 1'b1, 1'b0, 4'h0, 16'hA5A5, 16'h0000, "wr_restore");
        add_vec(1'b1, 1'b1, 1'b0, 4'h8, 16'h1234, 16'h0000, "wr_period");
        add_vec(1'b1, 1'b0, 1'b1, 4'h8, 16'h0000, 16'h1234, "rd_period");
        add_vec(1'b1, 1'b1, 1'b0, 4'h8, 16'h0000, 16'h0000, "wr_period_clr");
        add_vec(1'b1, 1'b1, 1'b0, 4'hA, 16'hFFF7, 16'h0000, "wr_duty");
        add_vec(1'b1, 1'b0, 1'b1, 4'hA, 16'h0000, 16'h0007, "rd_duty");
        add_vec(1'b1, 1'b1, 1'b0, 4'hA, 16'h000F, 16'h0000, "wr_duty_full");

        // Reset state
        repeat (2) @(posedge led_clk);
        #1;
        check("rst_ledout", {8'h00, ledout}, 32'h0);
        check("rst_rdata", {16'h0000, bus.ledrdata}, 32'h0);
        @(negedge led_clk);
        ledrst = 1'b0;

        // DATA writes and write-to-pin latency
        wr(4'h0, 16'hA5A5);
        wr(4'h2, 16'h003C);
        check("led_after_lo_only", {8'h00, ledout}, 32'h0000A5A5);
        @(posedge led_clk);
        #1;
        check("led_static", {8'h00, ledout}, 32'h003CA5A5);

        // Register table
        foreach (vecs[i]) begin
            bus_op(vecs[i].cs, vecs[i].wr, vecs[i].rd, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp, vecs[i].name);
        end
        @(posedge led_clk);
        #1;
        check("led_after_table", {8'h00, ledout}, 32'h003CA5A5);

        // Blink: low nibble masked, half-period 4
        wr(4'h4, 16'h000F);
        wr(4'h8, 16'h0004);
        blink_check(4, 32'h003CA5A5, 32'h0000000F, 16, "blink_p4");

        // PWM brightness with timer frozen
        wr(4'h8, 16'h0000);
        wr(4'hA, 16'h0004);
        pwm_check(4, 32'h003CA5A5, "pwm_duty4");
        wr(4'hA, 16'h0000);
        pwm_check(0, 32'h003CA5A5, "pwm_duty0");
        wr(4'hA, 16'h000F);
        pwm_check(16, 32'h003CA5A5, "pwm_duty15");

        // CTRL clear and disable
        wr(4'hC, 16'h0003);
        @(posedge led_clk);
        #1;
        check("ctrl_clr_led", {8'h00, ledout}, 32'h0);
        rd(4'h0, 16'h0000, "ctrl_clr_val_lo");
        rd(4'h2, 16'h0000, "ctrl_clr_val_hi");
        rd(4'hC, 16'h0001, "ctrl_clr_bit_reads0");
        wr(4'h0, 16'h00FF);
        wr(4'hC, 16'h0000);
        repeat (2) @(posedge led_clk);
        #1;
        check("ctrl_disabled_led", {8'h00, ledout}, 32'h0);
        rd(4'hC, 16'h0000, "rd_ctrl_disabled");
        wr(4'hC, 16'h0001);
        @(posedge led_clk);
        #1;
        check("ctrl_reenabled_led", {8'h00, ledout}, 32'h000000FF);

        // Asynchronous reset mid-blink with PWM active
        wr(4'h2, 16'h003C);
        wr(4'h8, 16'h0003);
        wr(4'hA, 16'h0008);
        rd(4'hA, 16'h0008, "rd_duty8");
        repeat (5) @(posedge led_clk);
        #2;
        ledrst = 1'b1;
        #1;
        check("async_rst_ledout", {8'h00, ledout}, 32'h0);
        check("async_rst_rdata", {16'h0000, bus.ledrdata}, 32'h0);
        repeat (2) @(negedge led_clk);
        ledrst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge led_clk);
            #1;
            check("post_rst_led_zero", {8'h00, ledout}, 32'h0);
        end
        rd(4'hA, 16'h000F, "post_rst_duty");
        rd(4'h8, 16'h0000, "post_rst_period");
        rd(4'h4, 16'h0000, "post_rst_mask");
        rd(4'hC, 16'h0001, "post_rst_ctrl");
        wr(4'h0, 16'h000F);
        wr(4'h4, 16'h000F);
        wr(4'h8, 16'h0002);
        blink_check(2, 32'h0000000F, 32'h0000000F, 8, "blink_restart_p2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
